// File: rtl/sti_rx.sv
// Serial-to-byte receiver: assembles MSB-first bursts into byte writes,
// then pads the remaining 256-byte memory with FILL_VALUE on rx_end.
module sti_rx #(
  parameter logic [7:0]  FILL_VALUE = 8'h00,
  parameter int unsigned MAX_BURST  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       so_data,
  input  logic       so_valid,
  input  logic       rx_end,
  output logic       mem_wr,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       rx_done,
  output logic       err_len,
  output logic       ovf
);

  localparam int unsigned BW = 6;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [7:0]    wptr_q, wptr_d;
  logic          full_q, full_d;
  logic          end_pend_q, end_pend_d;
  logic          len_err_q, len_err_d;
  logic          mem_wr_q, mem_wr_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          rx_done_q, rx_done_d;
  logic          err_len_q, err_len_d;
  logic          ovf_q, ovf_d;

  logic          wr_req;
  logic [7:0]    wr_val;
  logic [7:0]    byte_c;

  assign byte_c = {shift_q[6:0], so_data};

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    burst_cnt_d = burst_cnt_q;
    wptr_d      = wptr_q;
    full_d      = full_q;
    end_pend_d  = end_pend_q;
    len_err_d   = len_err_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rx_done_d   = rx_done_q;
    err_len_d   = 1'b0;
    ovf_d       = ovf_q;
    wr_req      = 1'b0;
    wr_val      = FILL_VALUE;

    if (rx_end && (state_q != S_DONE)) end_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (end_pend_q && !mem_wr_q) begin
          if (full_q) begin
            state_d   = S_DONE;
            rx_done_d = 1'b1;
          end else begin
            state_d = S_FILL;
            wr_req  = 1'b1;
          end
        end else if (so_valid) begin
          state_d     = S_RECV;
          shift_d     = byte_c;
          bit_cnt_d   = 3'd1;
          burst_cnt_d = BW'(1);
        end
      end
      S_RECV: begin
        if (!so_valid) begin
          // Burst over: a partial byte is dropped and flagged.
          state_d     = S_IDLE;
          bit_cnt_d   = 3'd0;
          burst_cnt_d = '0;
          len_err_d   = 1'b0;
          err_len_d   = (bit_cnt_q != 3'd0) && !len_err_q;
        end else if (burst_cnt_q == BURST_MAX) begin
          if (!len_err_q) begin
            err_len_d = 1'b1;
            len_err_d = 1'b1;
          end
        end else begin
          shift_d     = byte_c;
          bit_cnt_d   = bit_cnt_q + 3'd1;
          burst_cnt_d = burst_cnt_q + BW'(1);
          if (bit_cnt_q == 3'd7) begin
            if (full_q) begin
              ovf_d = 1'b1;
            end else begin
              wr_req = 1'b1;
              wr_val = byte_c;
            end
          end
        end
      end
      S_FILL: begin
        if (full_q) begin
          state_d   = S_DONE;
          rx_done_d = 1'b1;
        end else begin
          wr_req = 1'b1;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Single write port: pointer saturates into the full flag after 255.
    if (wr_req) begin
      mem_wr_d   = 1'b1;
      mem_addr_d = wptr_q;
      mem_data_d = wr_val;
      if (wptr_q == 8'hFF) full_d = 1'b1;
      else                 wptr_d = wptr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      burst_cnt_q <= '0;
      wptr_q      <= '0;
      full_q      <= 1'b0;
      end_pend_q  <= 1'b0;
      len_err_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rx_done_q   <= 1'b0;
      err_len_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      wptr_q      <= wptr_d;
      full_q      <= full_d;
      end_pend_q  <= end_pend_d;
      len_err_q   <= len_err_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rx_done_q   <= rx_done_d;
      err_len_q   <= err_len_d;
      ovf_q       <= ovf_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign rx_done  = rx_done_q;
  assign err_len  = err_len_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_sti_rx.sv
// Bench for sti_rx: a per-cycle timeline of expected outputs is built from
// burst/end transactions and compared against the DUT on every negedge.
module tb_sti_rx;

  localparam int NCYC = 16384;
  localparam int MAXB = 32;
  localparam int INF  = 1 << 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       so_data = 1'b0;
  logic       so_valid = 1'b0;
  logic       rx_end = 1'b0;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       rx_done;
  logic       err_len;
  logic       ovf;

  sti_rx #(.FILL_VALUE(8'h00), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .rx_end(rx_end), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .rx_done(rx_done), .err_len(err_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output timeline, indexed by cycle.
  bit         exp_wr  [NCYC];
  logic [7:0] exp_addr[NCYC];
  logic [7:0] exp_data[NCYC];
  bit         exp_err [NCYC];
  int ovf_from  = INF;
  int done_from = INF;
  int nwr       = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("mem_wr", 32'(mem_wr), 32'(exp_wr[cyc]));
      if (exp_wr[cyc]) begin
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
        chk("mem_data", 32'(mem_data), 32'(exp_data[cyc]));
      end
      chk("err_len", 32'(err_len), 32'(exp_err[cyc]));
      chk("ovf", 32'(ovf), 32'(cyc >= ovf_from));
      chk("rx_done", 32'(rx_done), 32'(cyc >= done_from));
    end
  end

  function automatic void model_reset(input int rc);
    for (int i = rc; i < NCYC; i++) begin
      exp_wr[i] = 1'b0; exp_err[i] = 1'b0;
      exp_addr[i] = 8'h00; exp_data[i] = 8'h00;
    end
    ovf_from = INF; done_from = INF; nwr = 0;
  endfunction

  // Burst of L bits (first bit = bits[L-1]) whose first bit is in cycle t0.
  function automatic void model_burst(input int t0, input int L, input logic [63:0] bits);
    int eff;
    int t;
    eff = (L > MAXB) ? MAXB : L;
    for (int k = 0; k < eff / 8; k++) begin
      t = t0 + 8 * k + 8;
      if (nwr < 256) begin
        exp_wr[t] = 1'b1;
        exp_addr[t] = 8'(nwr);
        exp_data[t] = bits[L-1-8*k -: 8];
        nwr++;
      end else if (t < ovf_from) begin
        ovf_from = t;
      end
    end
    if (L > MAXB) exp_err[t0 + MAXB + 1] = 1'b1;
    else if ((L % 8) != 0) exp_err[t0 + L + 1] = 1'b1;
  endfunction

  // tidle: first cycle idle with the end request already latched.
  function automatic void model_end(input int tidle);
    int n;
    n = 256 - nwr;
    for (int j = 0; j < n; j++) begin
      exp_wr[tidle + 1 + j] = 1'b1;
      exp_addr[tidle + 1 + j] = 8'(nwr + j);
      exp_data[tidle + 1 + j] = 8'h00;
    end
    done_from = tidle + 1 + n;
    nwr = 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; so_valid = 1'b0; rx_end = 1'b0;
    model_reset(cyc);
    #1;
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_burst(input logic [63:0] bits, input int L, input int end_idx,
                            input int gap, output int t0);
    t0 = 0;
    for (int i = 0; i < L; i++) begin
      tick();
      if (i == 0) begin
        t0 = cyc;
        model_burst(t0, L, bits);
        if (end_idx >= 0) model_end(t0 + L + 1);
      end
      so_valid = 1'b1;
      so_data = bits[L-1-i];
      rx_end = (i == end_idx);
    end
    tick();
    so_valid = 1'b0; so_data = 1'($urandom); rx_end = 1'b0;
    repeat (gap) begin
      tick();
      so_data = 1'($urandom);
    end
  endtask

  task automatic send_end();
    tick();
    model_end(cyc + 1);
    rx_end = 1'b1;
    tick();
    rx_end = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    for (int i = 0; i < NCYC && cyc < c; i++) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, c, cnt, L, nb, mode, e, g;
    logic [7:0] ref6 [6];
    ref6 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hBE, 8'hEF};

    do_reset();

    // Single A5 byte.
    send_burst(64'hA5, 8, -1, 2, t1);
    chk("pin_a5_wr", 32'(exp_wr[t1 + 8]), 32'd1);
    chk("pin_a5_data", 32'(exp_data[t1 + 8]), 32'hA5);
    chk("a5_data", 32'(mem_data), 32'hA5);
    chk("a5_addr", 32'(mem_addr), 32'd0);

    // 32-bit then 16-bit burst.
    do_reset();
    send_burst(64'h12345678, 32, -1, 1, t1);
    send_burst(64'hBEEF, 16, -1, 2, t2);
    for (int k = 0; k < 4; k++) begin
      chk("pin_seq_data", 32'(exp_data[t1 + 8 + 8 * k]), 32'(ref6[k]));
      chk("pin_seq_addr", 32'(exp_addr[t1 + 8 + 8 * k]), 32'(k));
    end
    for (int k = 0; k < 2; k++) begin
      chk("pin_seq_data", 32'(exp_data[t2 + 8 + 8 * k]), 32'(ref6[4 + k]));
      chk("pin_seq_addr", 32'(exp_addr[t2 + 8 + 8 * k]), 32'(4 + k));
    end
    chk("seq_last_data", 32'(mem_data), 32'hEF);
    chk("seq_last_addr", 32'(mem_addr), 32'd5);

    // 12-bit burst: one byte, length error, next byte at address 1.
    do_reset();
    send_burst(64'hABC, 12, -1, 2, t1);
    chk("pin_err12", 32'(exp_err[t1 + 13]), 32'd1);
    send_burst(64'h5A, 8, -1, 2, t2);
    chk("pin_next_addr", 32'(exp_addr[t2 + 8]), 32'd1);
    chk("after12_addr", 32'(mem_addr), 32'd1);
    chk("after12_data", 32'(mem_data), 32'h5A);

    // Three bytes then end: fill 3..255.
    do_reset();
    send_burst(64'h010203, 24, -1, 0, t1);
    send_end();
    cnt = 0;
    for (int i = t1 + 25; i < NCYC; i++) if (exp_wr[i]) cnt++;
    chk("pin_fill_count", 32'(cnt), 32'd253);
    chk("pin_fill_first", 32'(exp_addr[t1 + 27]), 32'd3);
    wait_cycle(done_from + 1);
    chk("fill_done", 32'(rx_done), 32'd1);
    chk("fill_last_addr", 32'(mem_addr), 32'd255);
    chk("fill_last_data", 32'(mem_data), 32'h00);

    // 65 x 32-bit bursts: overflow, then end goes straight to done.
    do_reset();
    for (int b = 0; b < 65; b++) send_burst({32'h0, 32'($urandom)}, 32, -1, 0, t1);
    send_end();
    wait_cycle(done_from + 2);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_done", 32'(rx_done), 32'd1);
    chk("ovf_addr", 32'(mem_addr), 32'd255);

    // End with first bit of a burst, then reset mid-fill at address 100.
    do_reset();
    send_burst(64'hC33C, 16, 0, 0, t1);
    c = t1 + 17 + 1 + 98;
    chk("pin_fill100", 32'(exp_addr[c]), 32'd100);
    wait_cycle(c);
    chk("fill100_wr", 32'(mem_wr), 32'd1);
    chk("fill100_addr", 32'(mem_addr), 32'd100);
    reset = 1'b1;
    model_reset(cyc);
    #1;
    chk("midfill_rst_wr", 32'(mem_wr), 32'd0);
    chk("midfill_rst_addr", 32'(mem_addr), 32'd0);
    chk("midfill_rst_data", 32'(mem_data), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    send_burst(64'h96, 8, -1, 2, t2);
    chk("post_rst_addr", 32'(mem_addr), 32'd0);
    chk("post_rst_data", 32'(mem_data), 32'h96);

    // Randomized sessions, each ending in done with so_valid noise afterwards.
    for (int it = 0; it < 5; it++) begin
      do_reset();
      nb = int'($urandom_range(1, 8));
      mode = int'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 0) L = 8 * int'($urandom_range(1, 4));
        else L = int'($urandom_range(1, 40));
        e = (mode == 0 && b == nb - 1) ? int'($urandom_range(0, L - 1)) : -1;
        g = (b == nb - 1) ? 0 : int'($urandom_range(0, 2));
        send_burst({32'($urandom), 32'($urandom)}, L, e, g, t1);
      end
      if (mode == 1) send_end();
      wait_cycle(done_from + 1);
      chk("rand_done", 32'(rx_done), 32'd1);
      repeat (20) begin
        tick();
        so_valid = 1'($urandom);
        so_data = 1'($urandom);
        rx_end = 1'($urandom);
      end
      tick();
      so_valid = 1'b0; rx_end = 1'b0;
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sti_rx.md
STI_RX -- requirements
Module: sti_rx

Interface
REQ-001 Parameter FILL_VALUE, default 8'h00, byte written to every unwritten address during the fill phase.
REQ-002 Parameter MAX_BURST, default 32, maximum legal burst length in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 so_data  input  1  serial data bit from the upstream serializer, MSB of each byte first.
REQ-006 so_valid  input  1  so_data is valid this cycle; a burst is one contiguous run of so_valid=1.
REQ-007 rx_end  input  1  single-cycle pulse: the last burst has been sent; pad memory and finish.
REQ-008 mem_wr  output  1  byte write strobe, one cycle per byte.
REQ-009 mem_addr  output  8  write address.
REQ-010 mem_data  output  8  write data.
REQ-011 rx_done  output  1  all 256 addresses written; held high until reset.
REQ-012 err_len  output  1  one-cycle pulse: burst length not a multiple of 8, or burst longer than MAX_BURST.
REQ-013 ovf  output  1  sticky: a byte arrived after address 255 had been written.

Function
REQ-014 The block SHALL implement states IDLE, RECV, FILL and DONE.
REQ-015 IDLE->RECV SHALL occur on so_valid=1; that first bit is captured in the same edge.
REQ-016 In RECV, each cycle with so_valid=1 SHALL shift so_data into an 8-bit shift register LSB-side (shift left), increment a 3-bit bit counter, and increment a 6-bit burst counter.
REQ-017 When the 8th bit of a byte is captured, mem_wr SHALL be 1 on the next cycle, with mem_data equal to the assembled byte (first bit received in bit 7) and mem_addr equal to the write pointer.
REQ-018 The write pointer SHALL reset to 0, increment by 1 after each write, and saturate at a full flag after the write to 255.
REQ-019 Back-to-back bytes SHALL be written on consecutive byte boundaries with no stall; the block has no backpressure.
REQ-020 RECV->IDLE SHALL occur on the first cycle with so_valid=0; the bit counter and burst counter SHALL clear at that edge.
REQ-021 If the bit counter is nonzero at that edge, err_len SHALL pulse for one cycle and the partial byte SHALL be discarded (not written).
REQ-022 When the burst counter would exceed MAX_BURST, err_len SHALL pulse once and the bits beyond MAX_BURST SHALL be ignored until the burst ends.
REQ-023 A byte completing while full is set SHALL NOT be written; instead ovf SHALL be set and held until reset.
REQ-024 An rx_end pulse arriving in any state other than DONE SHALL be latched in an end_pend flag.
REQ-025 IDLE with end_pend=1 and no write pending SHALL go to FILL, or to DONE directly if full=1.
REQ-026 In FILL, the block SHALL write FILL_VALUE at the write pointer every cycle (mem_wr=1) through address 255 inclusive, then enter DONE.
REQ-027 so_valid SHALL be ignored in FILL and DONE.
REQ-028 In DONE, rx_done SHALL be 1, mem_wr SHALL be 0, and the state SHALL hold until reset.
REQ-029 rx_end and so_valid=1 in the same cycle: the bit SHALL be captured and the end acted on after the burst ends.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset assertion, asynchronously: state=IDLE, mem_wr=0, mem_addr=0, mem_data=0, rx_done=0, err_len=0, ovf=0, and the write pointer, counters, full and end_pend all cleared.
REQ-032 Reset mid-burst or mid-FILL SHALL abandon all pending data; no write SHALL occur in the first cycle after release.

Verification
REQ-033 8-bit burst 1,0,1,0,0,1,0,1 -> one cycle after the 8th bit: mem_wr=1, mem_addr=0, mem_data=8'hA5.
REQ-034 32-bit burst 0x12345678 then a 16-bit burst 0xBEEF -> writes 12,34,56,78,BE,EF at addresses 0-5, each one cycle after its byte boundary.
REQ-035 12-bit burst -> one byte written at address 0, err_len pulses one cycle after so_valid falls, the next byte is written at address 1.
REQ-036 3 bytes received, then rx_end -> FILL writes 8'h00 at addresses 3..255 on 253 consecutive cycles, then rx_done=1.
REQ-037 260 bytes streamed (as 65 bursts of 32 bits) -> addresses 0..255 written, ovf=1, rx_end -> DONE with no FILL writes.
REQ-038 Reset asserted mid-FILL at address 100 -> outputs clear immediately; a new 8-bit burst writes to address 0.
